// File: rtl/if_fetch_unit.sv
// if_fetch_unit: F-stage fetch unit. Owns the PC, runs a single-outstanding
// request/response handshake with instruction memory, applies exception, eret
// and delayed-branch redirects, and flags misaligned or out-of-range fetch
// addresses as AdEL (code 4).
// Optional build macro: FETCH_STALL_CNT_EN enables the fetch-wait cycle counter
// on stall_cnt. Without it, stall_cnt is tied to 0.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_PC   = 32'h0000_4180,
    parameter logic [31:0] PC_LO    = 32'h0000_3000,
    parameter logic [31:0] PC_HI    = 32'h0000_6ffc
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        eret_d,
    input  logic [31:0] epc,
    input  logic        br_taken_d,
    input  logic [31:0] br_target_d,
    input  logic        d_is_branch,
    input  logic        id_en,
    output logic        i_req,
    output logic [31:0] i_addr,
    input  logic        i_rvalid,
    input  logic [31:0] i_rdata,
    output logic        f_valid,
    output logic [31:0] pc_f,
    output logic [31:0] instr_f,
    output logic        bd_f,
    output logic [4:0]  exc_code_f,
    output logic [31:0] stall_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_HOLD, S_DROP} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_pend_tgt;
    logic        r_pend_tgt_v;
    logic        r_bd_pend;
    logic [31:0] r_hold;

    logic        w_redirect;
    logic [31:0] w_redir_pc;
    logic        w_adel;
    logic        w_fv;
    logic [31:0] w_instr;
    logic [4:0]  w_exc;
    logic        w_ireq;
    logic        w_accept;
    logic [31:0] w_next_pc;

    assign w_redirect = req | eret_d;
    assign w_redir_pc = req ? EXC_PC : epc;
    assign w_adel     = (r_pc[1:0] != 2'b00) || (r_pc < PC_LO) || (r_pc > PC_HI);

    // Per-state view of the F slot and the memory request for this cycle
    always_comb begin
        w_fv    = 1'b0;
        w_instr = 32'd0;
        w_exc   = 5'd0;
        w_ireq  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_adel) begin
                    // Bad fetch address: present a faulting nop, never touch memory
                    w_fv  = 1'b1;
                    w_exc = 5'd4;
                end else if (!w_redirect) begin
                    w_ireq = 1'b1;
                end
            end
            S_BUSY: begin
                // A response arriving under a redirect is squashed, never shown
                w_fv    = i_rvalid & ~w_redirect;
                w_instr = w_fv ? i_rdata : 32'd0;
            end
            S_HOLD: begin
                w_fv    = 1'b1;
                w_instr = r_hold;
            end
            default: ;
        endcase
    end

    // Outputs read zero while reset is held, except the PC
    assign f_valid    = w_fv & ~reset;
    assign instr_f    = reset ? 32'd0 : w_instr;
    assign exc_code_f = reset ? 5'd0 : w_exc;
    assign i_req      = w_ireq & ~reset;
    assign i_addr     = i_req ? r_pc : 32'd0;
    assign pc_f       = r_pc;
    assign bd_f       = ~reset & (d_is_branch | r_bd_pend);

    // The F instruction moves into ID this cycle; the branch target takes effect
    // only once the delay slot has been accepted
    assign w_accept  = f_valid & id_en;
    assign w_next_pc = br_taken_d   ? br_target_d :
                       r_pend_tgt_v ? r_pend_tgt  : r_pc + 32'd4;

    // Fetch FSM with PC, pending-branch and hold-buffer bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_pend_tgt_v <= 1'b0;
            r_pend_tgt   <= 32'd0;
            r_bd_pend    <= 1'b0;
            r_hold       <= 32'd0;
        end else if (w_redirect) begin
            r_pc         <= w_redir_pc;
            r_pend_tgt_v <= 1'b0;
            r_bd_pend    <= 1'b0;
            case (r_state)
                // An in-flight request must still drain unless it lands right now
                S_BUSY:  r_state <= i_rvalid ? S_IDLE : S_DROP;
                S_DROP:  r_state <= S_DROP;
                default: r_state <= S_IDLE;
            endcase
        end else begin
            if (w_accept) begin
                r_pc         <= w_next_pc;
                r_pend_tgt_v <= 1'b0;
                r_bd_pend    <= 1'b0;
            end else if (id_en) begin
                // ID consumed a bubble: remember the branch for the real delay slot
                if (br_taken_d) begin
                    r_pend_tgt_v <= 1'b1;
                    r_pend_tgt   <= br_target_d;
                end
                if (d_is_branch) r_bd_pend <= 1'b1;
            end
            case (r_state)
                S_IDLE: if (!w_adel) r_state <= S_BUSY;
                S_BUSY: begin
                    if (i_rvalid) begin
                        if (id_en) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_hold  <= i_rdata;
                            r_state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: if (id_en) r_state <= S_IDLE;
                S_DROP: if (i_rvalid) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Count cycles spent waiting on memory with nothing to hand to ID
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= 32'd0;
        end else if ((r_state == S_BUSY || r_state == S_DROP) && !f_valid) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: inputs change on the falling edge, outputs
// are checked 1 ns later, state commits on the rising edge.
module tb_if_fetch_unit;

    logic        clk;
    logic        reset;
    logic        req;
    logic        eret_d;
    logic [31:0] epc;
    logic        br_taken_d;
    logic [31:0] br_target_d;
    logic        d_is_branch;
    logic        id_en;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        f_valid;
    logic [31:0] pc_f;
    logic [31:0] instr_f;
    logic        bd_f;
    logic [4:0]  exc_code_f;
    logic [31:0] stall_cnt;

    int n_chk = 0;
    int n_err = 0;

    if_fetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .eret_d     (eret_d),
        .epc        (epc),
        .br_taken_d (br_taken_d),
        .br_target_d(br_target_d),
        .d_is_branch(d_is_branch),
        .id_en      (id_en),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_rvalid   (i_rvalid),
        .i_rdata    (i_rdata),
        .f_valid    (f_valid),
        .pc_f       (pc_f),
        .instr_f    (instr_f),
        .bd_f       (bd_f),
        .exc_code_f (exc_code_f),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Move to the next falling edge; caller then sets inputs and settles
    task automatic nxt();
        @(negedge clk);
    endtask

    localparam logic [31:0] D0 = 32'h2401_0001;
    localparam logic [31:0] D1 = 32'h2402_0002;
    localparam logic [31:0] D2 = 32'h2403_0003;
    localparam logic [31:0] D3 = 32'h2404_0004;
    localparam logic [31:0] D4 = 32'h2405_0005;
    localparam logic [31:0] D5 = 32'h2406_0006;
    localparam logic [31:0] D6 = 32'h2407_0007;
    localparam logic [31:0] D7 = 32'h2408_0008;

`ifdef FETCH_STALL_CNT_EN
    localparam logic [31:0] STALL_EXP = 32'd10;
`else
    localparam logic [31:0] STALL_EXP = 32'd0;
`endif

    initial begin
        reset = 1'b1; req = 1'b0; eret_d = 1'b0; epc = 32'd0;
        br_taken_d = 1'b0; br_target_d = 32'd0; d_is_branch = 1'b0;
        id_en = 1'b0; i_rvalid = 1'b0; i_rdata = 32'd0;
        repeat (2) @(posedge clk);

        // Reset state
        nxt(); #1;
        chk("rst_i_req", i_req, 0);
        chk("rst_i_addr", i_addr, 0);
        chk("rst_f_valid", f_valid, 0);
        chk("rst_pc_f", pc_f, 32'h3000);
        chk("rst_instr_f", instr_f, 0);
        chk("rst_bd_f", bd_f, 0);
        chk("rst_exc", exc_code_f, 0);
        chk("rst_stall", stall_cnt, 0);

        // Sequential fetch, 1-cycle memory, id_en high
        reset = 1'b0; id_en = 1'b1; #1;
        chk("A_i_req", i_req, 1);
        chk("A_i_addr", i_addr, 32'h3000);
        nxt(); i_rvalid = 1'b1; i_rdata = D0; #1;
        chk("B_f_valid", f_valid, 1);
        chk("B_instr", instr_f, D0);
        chk("B_pc_f", pc_f, 32'h3000);
        chk("B_exc", exc_code_f, 0);
        chk("B_i_req", i_req, 0);
        nxt(); i_rvalid = 1'b0; #1;
        chk("C_i_addr", i_addr, 32'h3004);
        chk("C_f_valid", f_valid, 0);
        nxt(); i_rvalid = 1'b1; i_rdata = D1; #1;
        chk("D_instr", instr_f, D1);
        chk("D_pc_f", pc_f, 32'h3004);
        nxt(); i_rvalid = 1'b0; #1;
        chk("E_i_addr", i_addr, 32'h3008);

        // Delay slot 0x3008 accepted with taken branch to 0x3100 in D
        nxt(); i_rvalid = 1'b1; i_rdata = D2;
        d_is_branch = 1'b1; br_taken_d = 1'b1; br_target_d = 32'h3100; #1;
        chk("F_f_valid", f_valid, 1);
        chk("F_instr", instr_f, D2);
        chk("F_bd_f", bd_f, 1);
        chk("F_exc", exc_code_f, 0);
        nxt(); i_rvalid = 1'b0; d_is_branch = 1'b0; br_taken_d = 1'b0; #1;
        chk("G_i_addr", i_addr, 32'h3100);
        chk("G_bd_f", bd_f, 0);

        // Response while ID stalls: buffered in HOLD for 3 cycles
        nxt(); id_en = 1'b0; i_rvalid = 1'b1; i_rdata = D3; #1;
        chk("H_instr", instr_f, D3);
        nxt(); i_rvalid = 1'b0; i_rdata = 32'hdead_beef; #1;
        chk("I_f_valid", f_valid, 1);
        chk("I_instr", instr_f, D3);
        chk("I_i_req", i_req, 0);
        nxt(); #1;
        chk("J_instr", instr_f, D3);
        chk("J_pc_f", pc_f, 32'h3100);
        nxt(); id_en = 1'b1; #1;
        chk("K_instr", instr_f, D3);
        chk("K_i_req", i_req, 0);
        nxt(); #1;
        chk("L_i_addr", i_addr, 32'h3104);

        // Exception while 0x3104 is outstanding: DROP, late word discarded
        nxt(); req = 1'b1; #1;
        chk("M_f_valid", f_valid, 0);
        chk("M_i_req", i_req, 0);
        nxt(); req = 1'b0; #1;
        chk("N_pc_f", pc_f, 32'h4180);
        chk("N_i_req", i_req, 0);
        nxt(); i_rvalid = 1'b1; i_rdata = 32'hbad0_bad0; #1;
        chk("O_f_valid", f_valid, 0);
        chk("O_instr", instr_f, 0);
        nxt(); i_rvalid = 1'b0; #1;
        chk("P_i_addr", i_addr, 32'h4180);
        chk("P_f_valid", f_valid, 0);
        nxt(); i_rvalid = 1'b1; i_rdata = D4; #1;
        chk("Q_instr", instr_f, D4);
        chk("Q_pc_f", pc_f, 32'h4180);

        // eret to misaligned epc: AdEL, no memory request
        nxt(); i_rvalid = 1'b0; id_en = 1'b0; eret_d = 1'b1; epc = 32'h3002; #1;
        chk("R_i_req", i_req, 0);
        nxt(); eret_d = 1'b0; #1;
        chk("S_i_req", i_req, 0);
        chk("S_f_valid", f_valid, 1);
        chk("S_instr", instr_f, 0);
        chk("S_exc", exc_code_f, 4);
        chk("S_pc_f", pc_f, 32'h3002);
        nxt(); id_en = 1'b1; #1;
        chk("T_exc", exc_code_f, 4);
        nxt(); id_en = 1'b0; eret_d = 1'b1; epc = 32'h3010; #1;
        chk("U_pc_f", pc_f, 32'h3006);
        chk("U_exc", exc_code_f, 4);
        nxt(); eret_d = 1'b0; id_en = 1'b1; #1;
        chk("V_i_addr", i_addr, 32'h3010);

        // Branch seen while F holds a bubble: target and bd deferred
        nxt(); br_taken_d = 1'b1; br_target_d = 32'h3200; d_is_branch = 1'b1; #1;
        chk("W_f_valid", f_valid, 0);
        chk("W_bd_f", bd_f, 1);
        nxt(); br_taken_d = 1'b0; d_is_branch = 1'b0; i_rvalid = 1'b1; i_rdata = D5; #1;
        chk("X_instr", instr_f, D5);
        chk("X_bd_f", bd_f, 1);
        chk("X_pc_f", pc_f, 32'h3010);
        nxt(); i_rvalid = 1'b0; #1;
        chk("Y_i_addr", i_addr, 32'h3200);
        chk("Y_bd_f", bd_f, 0);

        // Two fetches with 4-cycle latency
        repeat (3) nxt();
        nxt(); i_rvalid = 1'b1; i_rdata = D6; #1;
        chk("Z4_instr", instr_f, D6);
        nxt(); i_rvalid = 1'b0; #1;
        chk("Z5_i_addr", i_addr, 32'h3204);
        repeat (3) nxt();
        nxt(); i_rvalid = 1'b1; i_rdata = D7; #1;
        chk("Z9_instr", instr_f, D7);

        // Upper bound: 0x7000 faults, 0x6ffc is fetched
        nxt(); i_rvalid = 1'b0; id_en = 1'b0; eret_d = 1'b1; epc = 32'h7000; #1;
        chk("Z10_stall", stall_cnt, STALL_EXP);
        chk("Z10_i_req", i_req, 0);
        nxt(); epc = 32'h6ffc; #1;
        chk("Z11_pc_f", pc_f, 32'h7000);
        chk("Z11_exc", exc_code_f, 4);
        chk("Z11_f_valid", f_valid, 1);
        nxt(); eret_d = 1'b0; #1;
        chk("Z12_i_addr", i_addr, 32'h6ffc);
        chk("Z12_exc", exc_code_f, 0);

        // req coinciding with the response: word dropped, straight back to IDLE
        nxt(); req = 1'b1; id_en = 1'b1; i_rvalid = 1'b1; i_rdata = 32'h1234_5678; #1;
        chk("Z13_f_valid", f_valid, 0);
        nxt(); req = 1'b0; i_rvalid = 1'b0; #1;
        chk("Z14_i_req", i_req, 1);
        chk("Z14_i_addr", i_addr, 32'h4180);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
